pipe_hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline's fixed forwarding/hazard logic.
- Tracks in-flight destination-register writes in a shift-register scoreboard, one entry per post-decode stage (E, M, W, ...).
- Produces per-read-port forwarding selects for Execute, plus the stall and flush controls for Fetch, Decode and Execute.
- Depth, register count and read-port count are generic, so deeper or wider pipelines reuse the block.

---
 rtl/pipe_hazard_scoreboard_if.sv | 46 ++++
 rtl/pipe_hazard_scoreboard.sv | 126 ++++++++++++
 tb/tb_pipe_hazard_scoreboard.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_scoreboard_if.sv
// Decode/Execute hazard bus between the pipeline control and the scoreboard.
// HAZ_PERF_EN adds the stall/flush event counters.
interface pipe_hazard_scoreboard_if #(
  parameter int NREG   = 16,
  parameter int NRP    = 2,
  parameter int NSTAGE = 3
);
  localparam int AW = $clog2(NREG);
  localparam int FW = $clog2(NSTAGE);

  logic                d_valid;
  logic [AW-1:0]       d_rd;
  logic                d_we;
  logic                d_load;
  logic                d_pcwr;
  logic [NRP*AW-1:0]   d_rs;
  logic [NRP-1:0]      d_rs_used;
  logic                e_kill;
  logic                branch_taken_e;
  logic [NRP*FW-1:0]   fwd_sel;
  logic                stall_f;
  logic                stall_d;
  logic                flush_d;
  logic                flush_e;
  logic [NSTAGE-1:0]   pending;
`ifdef HAZ_PERF_EN
  logic [31:0]         stall_cnt;
  logic [31:0]         flush_cnt;
`endif

  modport master (
    output d_valid, d_rd, d_we, d_load, d_pcwr, d_rs, d_rs_used, e_kill, branch_taken_e,
    input  fwd_sel, stall_f, stall_d, flush_d, flush_e, pending
`ifdef HAZ_PERF_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  d_valid, d_rd, d_we, d_load, d_pcwr, d_rs, d_rs_used, e_kill, branch_taken_e,
    output fwd_sel, stall_f, stall_d, flush_d, flush_e, pending
`ifdef HAZ_PERF_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// Shift-register scoreboard of in-flight writes driving forwarding selects and
// F/D/E stall/flush controls. Define HAZ_PERF_EN for stall/flush event counters.
module pipe_hazard_scoreboard #(
  parameter int NREG   = 16,
  parameter int NRP    = 2,
  parameter int NSTAGE = 3,
  parameter int PC_REG = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  pipe_hazard_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int FW = $clog2(NSTAGE);

  typedef struct packed {
    logic              v;
    logic [AW-1:0]     rd;
    logic              we;
    logic              ld;
    logic              pcwr;
    logic [NRP*AW-1:0] rs;
    logic [NRP-1:0]    rs_used;
  } ent_t;

  ent_t              r_ent [NSTAGE];
  logic [NRP*FW-1:0] w_fwd_sel;
  logic [NRP-1:0]    w_near_ld;
  logic [NSTAGE-1:0] w_pending;
  logic              w_ldstall;
  logic              w_pcpend;
  logic              w_pcret;
  logic              w_stall_d;
  logic              w_flush_e;

  function automatic logic writes(input ent_t e, input logic [AW-1:0] r);
    return e.v & e.we & (e.rd == r);
  endfunction

  // NOTE: every combinational output gets a default before the loops so no latch is inferred.
  always_comb begin
    w_fwd_sel = '0;
    for (int p = 0; p < NRP; p++) begin
      for (int k = NSTAGE-1; k >= 1; k--)
        if (writes(r_ent[k], r_ent[0].rs[p*AW +: AW]))
          w_fwd_sel[p*FW +: FW] = FW'(k);
      if (!r_ent[0].rs_used[p] || r_ent[0].rs[p*AW +: AW] == AW'(PC_REG))
        w_fwd_sel[p*FW +: FW] = '0;
    end
  end

  // Walking oldest to youngest lets the nearest writer overwrite, so a
  // younger ALU write shadows an older load.
  always_comb begin
    w_ldstall = 1'b0;
    w_near_ld = '0;
    for (int p = 0; p < NRP; p++) begin
      for (int k = NSTAGE-1; k >= 0; k--)
        if (bus.d_rs_used[p] && writes(r_ent[k], bus.d_rs[p*AW +: AW]))
          w_near_ld[p] = r_ent[k].ld && (k < NSTAGE-2);
      w_ldstall = w_ldstall | w_near_ld[p];
    end
  end

  always_comb begin
    w_pcpend  = bus.d_valid & bus.d_pcwr;
    w_pending = '0;
    for (int k = 0; k < NSTAGE-1; k++)
      w_pcpend = w_pcpend | (r_ent[k].v & r_ent[k].pcwr);
    for (int k = 0; k < NSTAGE; k++)
      w_pending[k] = r_ent[k].v & r_ent[k].we;
  end

  assign w_pcret   = r_ent[NSTAGE-1].v & r_ent[NSTAGE-1].pcwr;
  assign w_stall_d = w_ldstall & ~bus.branch_taken_e;
  assign w_flush_e = w_ldstall | bus.branch_taken_e;

  assign bus.stall_f = reset & (w_ldstall | w_pcpend) & ~bus.branch_taken_e;
  assign bus.stall_d = reset & w_stall_d;
  assign bus.flush_e = reset & w_flush_e;
  assign bus.flush_d = reset & (bus.branch_taken_e | w_pcpend | w_pcret) & ~w_stall_d;
  assign bus.fwd_sel = reset ? w_fwd_sel : '0;
  assign bus.pending = reset ? w_pending : '0;

  // NOTE: only the valid bits are reset; payload fields are ignored while v=0.
  // NOTE: sequential state uses non-blocking assignments so every entry shifts from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NSTAGE; k++)
        r_ent[k].v <= 1'b0;
    end else begin
      for (int k = NSTAGE-1; k >= 2; k--)
        r_ent[k] <= r_ent[k-1];
      r_ent[1] <= r_ent[0];
      if (bus.e_kill) begin
        r_ent[1].we   <= 1'b0;
        r_ent[1].pcwr <= 1'b0;
      end
      if (w_flush_e || !bus.d_valid)
        r_ent[0] <= '0;
      else
        r_ent[0] <= '{v: 1'b1, rd: bus.d_rd, we: bus.d_we, ld: bus.d_load,
                      pcwr: bus.d_pcwr, rs: bus.d_rs, rs_used: bus.d_rs_used};
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_d && r_stall_cnt != 32'hFFFF_FFFF)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (bus.branch_taken_e && r_flush_cnt != 32'hFFFF_FFFF)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Scoreboard bench: the driver pushes expectations from an instruction-queue
// reference model; a monitor pops and compares them every falling edge.
module tb_pipe_hazard_scoreboard;
  localparam int NREG   = 16;
  localparam int NRP    = 2;
  localparam int NSTAGE = 3;
  localparam int PC_REG = 15;
  localparam int AW     = $clog2(NREG);
  localparam int FW     = $clog2(NSTAGE);

  logic clk;
  logic reset;

  pipe_hazard_scoreboard_if #(.NREG(NREG), .NRP(NRP), .NSTAGE(NSTAGE)) bus ();

  pipe_hazard_scoreboard #(.NREG(NREG), .NRP(NRP), .NSTAGE(NSTAGE), .PC_REG(PC_REG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
    bit pcwr;
    int rs[NRP];
    bit used[NRP];
  } minst_t;

  typedef struct {
    logic [NRP*FW-1:0] fwd;
    bit                sf;
    bit                sd;
    bit                fd;
    bit                fe;
    logic [NSTAGE-1:0] pend;
    logic [31:0]       sc;
    logic [31:0]       fc;
  } exp_t;

  minst_t pipe[$];
  exp_t   exp_q[$];
  int     total = 0;
  int     bad   = 0;
  logic [31:0] m_sc = '0;
  logic [31:0] m_fc = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, want, $time);
    end
  endtask

  function automatic minst_t blank();
    minst_t b;
    b.v = 0; b.rd = 0; b.we = 0; b.ld = 0; b.pcwr = 0;
    for (int p = 0; p < NRP; p++) begin
      b.rs[p] = 0;
      b.used[p] = 0;
    end
    return b;
  endfunction

  function automatic bit wr_match(input minst_t i, input int r);
    return i.v && i.we && (i.rd == r);
  endfunction

  // Drive one Decode cycle, predict this cycle's outputs, then advance the model.
  task automatic step(input bit rst, input bit vld, input int rd, input bit we, input bit ld,
                      input bit pcwr, input int rs0, input int rs1, input bit u0, input bit u1,
                      input bit kill, input bit bt);
    exp_t   e;
    minst_t ne;
    minst_t old;
    int     rs[NRP];
    bit     used[NRP];
    bit     ldstall;
    bit     pcpend;
    bit     pcret;
    @(posedge clk);
    #1;
    reset              = rst;
    bus.d_valid        = vld;
    bus.d_rd           = AW'(rd);
    bus.d_we           = we;
    bus.d_load         = ld;
    bus.d_pcwr         = pcwr;
    bus.d_rs           = {AW'(rs1), AW'(rs0)};
    bus.d_rs_used      = {u1, u0};
    bus.e_kill         = kill;
    bus.branch_taken_e = bt;
    rs[0] = rs0; rs[1] = rs1; used[0] = u0; used[1] = u1;

    ldstall = 0;
    for (int p = 0; p < NRP; p++)
      if (used[p])
        for (int k = 0; k < NSTAGE; k++)
          if (wr_match(pipe[k], rs[p])) begin
            if (pipe[k].ld && k < NSTAGE-2) ldstall = 1;
            break;
          end

    e.fwd = '0;
    for (int p = 0; p < NRP; p++)
      if (pipe[0].used[p] && pipe[0].rs[p] != PC_REG)
        for (int k = 1; k < NSTAGE; k++)
          if (wr_match(pipe[k], pipe[0].rs[p])) begin
            e.fwd[p*FW +: FW] = FW'(k);
            break;
          end

    pcpend = vld && pcwr;
    for (int k = 0; k < NSTAGE-1; k++)
      if (pipe[k].v && pipe[k].pcwr) pcpend = 1;
    pcret = pipe[NSTAGE-1].v && pipe[NSTAGE-1].pcwr;

    e.sf = (ldstall || pcpend) && !bt;
    e.sd = ldstall && !bt;
    e.fe = ldstall || bt;
    e.fd = (bt || pcpend || pcret) && !e.sd;
    for (int k = 0; k < NSTAGE; k++)
      e.pend[k] = pipe[k].v && pipe[k].we;
    if (!rst) begin
      e.fwd = '0; e.sf = 0; e.sd = 0; e.fe = 0; e.fd = 0; e.pend = '0;
    end
    e.sc = m_sc;
    e.fc = m_fc;
    exp_q.push_back(e);

    if (!rst) begin
      m_sc = '0;
      m_fc = '0;
      for (int k = 0; k < NSTAGE; k++) pipe[k] = blank();
    end else begin
      if (e.sd && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (bt && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      ne = blank();
      if (vld && !(ldstall || bt)) begin
        ne.v = 1; ne.rd = rd; ne.we = we; ne.ld = ld; ne.pcwr = pcwr;
        ne.rs = rs; ne.used = used;
      end
      if (kill) begin
        old = pipe[0];
        old.we = 0;
        old.pcwr = 0;
        pipe[0] = old;
      end
      pipe.push_front(ne);
      void'(pipe.pop_back());
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int pick();
    return ($urandom_range(0, 9) == 0) ? PC_REG : int'($urandom_range(0, 5));
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fwd_sel", 32'(bus.fwd_sel), 32'(e.fwd));
        check("stall_f", 32'(bus.stall_f), 32'(e.sf));
        check("stall_d", 32'(bus.stall_d), 32'(e.sd));
        check("flush_d", 32'(bus.flush_d), 32'(e.fd));
        check("flush_e", 32'(bus.flush_e), 32'(e.fe));
        check("pending", 32'(bus.pending), 32'(e.pend));
`ifdef HAZ_PERF_EN
        check("stall_cnt", bus.stall_cnt, e.sc);
        check("flush_cnt", bus.flush_cnt, e.fc);
`endif
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    reset = 1'b0;
    bus.d_valid = 0; bus.d_rd = '0; bus.d_we = 0; bus.d_load = 0; bus.d_pcwr = 0;
    bus.d_rs = '0; bus.d_rs_used = '0; bus.e_kill = 0; bus.branch_taken_e = 0;
    for (int k = 0; k < NSTAGE; k++) pipe.push_back(blank());

    // Reset with busy inputs: everything must read zero.
    step(0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1);
    step(0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1);
    @(negedge clk);
    check("rst_stall_f", 32'(bus.stall_f), 0);
    check("rst_flush_d", 32'(bus.flush_d), 0);
    check("rst_flush_e", 32'(bus.flush_e), 0);
    check("rst_pending", 32'(bus.pending), 0);

    // ALU chain: direct consumer forwards from M.
    step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    nop(1);
    @(negedge clk);
    check("alu_fwd_m", 32'(bus.fwd_sel[FW-1:0]), 1);
    nop(3);
    // ALU chain with one gap instruction forwards from W.
    step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    nop(1);
    @(negedge clk);
    check("alu_fwd_w", 32'(bus.fwd_sel[FW-1:0]), 2);
    nop(3);

    // Load-use: one stall cycle, then forward from W.
    step(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("lu_stall_f", 32'(bus.stall_f), 1);
    check("lu_stall_d", 32'(bus.stall_d), 1);
    check("lu_flush_e", 32'(bus.flush_e), 1);
    check("lu_flush_d", 32'(bus.flush_d), 0);
    step(1, 1, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("lu_release", 32'(bus.stall_d), 0);
    nop(1);
    @(negedge clk);
    check("lu_fwd_w", 32'(bus.fwd_sel[FW-1:0]), 2);
    nop(3);

    // Shadowing: youngest writer of r3 wins.
    step(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0);
    nop(1);
    @(negedge clk);
    check("shadow_fwd", 32'(bus.fwd_sel[FW-1:0]), 1);
    nop(3);

    // Condition fail: killed writer neither forwards nor shows pending.
    step(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 4, 0, 1, 0, 1, 0);
    nop(1);
    @(negedge clk);
    check("kill_fwd", 32'(bus.fwd_sel[FW-1:0]), 0);
    check("kill_pend1", 32'(bus.pending[1]), 0);
    nop(3);

    // Branch taken on top of a load-use hazard.
    step(1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 5, 0, 1, 0, 0, 1);
    @(negedge clk);
    check("bl_stall_f", 32'(bus.stall_f), 0);
    check("bl_stall_d", 32'(bus.stall_d), 0);
    check("bl_flush_d", 32'(bus.flush_d), 1);
    check("bl_flush_e", 32'(bus.flush_e), 1);
    nop(3);

    // PC write walks through the scoreboard.
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) nop(1);
      @(negedge clk);
      check($sformatf("pc_stall_f_c%0d", c), 32'(bus.stall_f), (c < 3) ? 1 : 0);
      check($sformatf("pc_flush_d_c%0d", c), 32'(bus.flush_d), (c < 4) ? 1 : 0);
    end

    // Reset mid PC-write sequence.
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    nop(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("mid_rst_flush_d", 32'(bus.flush_d), 0);
    nop(1);
    @(negedge clk);
    check("post_rst_pending", 32'(bus.pending), 0);
    check("post_rst_flush_d", 32'(bus.flush_d), 0);
    check("post_rst_stall_f", 32'(bus.stall_f), 0);

    // Randomised traffic over a small register window to provoke hazards.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 5)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
           pick(), pick(), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
